receive_instr: RTL and testbench



---
 rtl/receive_instr_if.sv | 23 ++
 rtl/receive_instr.sv | 79 +++++++
 tb/tb_receive_instr.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/receive_instr_if.sv
// receive_instr_if: transmitter sync/ack and fetch-side valid/ready bundle for receive_instr.
interface receive_instr_if #(
  parameter int IWIDTH = 32
);
  logic              r_i_start;
  logic              r_o_syn;
  logic [IWIDTH-1:0] r_i_instr;
  logic              r_i_ack;
  logic [IWIDTH-1:0] r_o_instr;
  logic              r_o_valid;
  logic              r_i_ready;
  logic              r_o_busy;
  logic              r_o_done;
  logic              r_o_err;
  modport slave (
    input  r_i_start, r_i_instr, r_i_ack, r_i_ready,
    output r_o_syn, r_o_instr, r_o_valid, r_o_busy, r_o_done, r_o_err
  );
  modport master (
    output r_i_start, r_i_instr, r_i_ack, r_i_ready,
    input  r_o_syn, r_o_instr, r_o_valid, r_o_busy, r_o_done, r_o_err
  );
endinterface

// File: rtl/receive_instr.sv
// receive_instr: paces the transmitter sync request, buffers acknowledged words in a
// show-ahead FIFO and hands them to the fetch stage over valid/ready.
module receive_instr #(
  parameter int IWIDTH     = 32,
  parameter int NUM_INSTR  = 36,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            r_clk,
  input  logic            r_rst,
  receive_instr_if.slave  bus
);
  localparam int CW = $clog2(NUM_INSTR + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam int SW = CW + FW;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic              syn_q, syn_d, syn_dly_q, err_q;
  logic [CW-1:0]     launched_q, launched_d, received_q, received_d, outstanding;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]     count_q, count_d;
  logic [IWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic              launch, start, pop, push, drop;
  logic [SW-1:0]     need;
  always_comb begin
    launch      = syn_q & syn_dly_q;
    start       = (state_q == IDLE) & bus.r_i_start;
    outstanding = launched_q - received_q;
    pop         = (count_q != '0) & bus.r_i_ready;
    push        = bus.r_i_ack & (outstanding != '0) & ((count_q != FW'(FIFO_DEPTH)) | pop);
    drop        = bus.r_i_ack & ~push;
    launched_d  = start ? '0 : launched_q + CW'(launch);
    received_d  = start ? '0 : received_q + CW'(push);
    count_d     = count_q + FW'(push) - FW'(pop);
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = bus.r_i_start ? FETCH : IDLE;
      FETCH:   state_d = (launched_d == CW'(NUM_INSTR)) ? DRAIN : FETCH;
      DRAIN:   state_d = (received_d == CW'(NUM_INSTR)) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    // reserve a slot for every word already in flight plus the one this request would launch
    need  = SW'(count_d) + SW'(CW'(launched_d - received_d)) + SW'(1);
    syn_d = (state_d == FETCH) & (launched_d < CW'(NUM_INSTR)) & (need <= SW'(FIFO_DEPTH));
  end
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q    <= IDLE;
      syn_q      <= 1'b0;
      syn_dly_q  <= 1'b0;
      err_q      <= 1'b0;
      launched_q <= '0;
      received_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      syn_q      <= syn_d;
      syn_dly_q  <= syn_q;
      err_q      <= err_q | drop;
      launched_q <= launched_d;
      received_q <= received_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.r_i_instr;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
  assign bus.r_o_syn   = syn_q;
  assign bus.r_o_instr = mem_q[rd_ptr_q];
  assign bus.r_o_valid = count_q != '0;
  assign bus.r_o_busy  = state_q != IDLE;
  assign bus.r_o_done  = state_q == DONE;
  assign bus.r_o_err   = err_q;
endmodule

// File: tb/tb_receive_instr.sv
// tb_receive_instr: directed bench for receive_instr with a behavioural transmitter.
module tb_receive_instr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  receive_instr_if #(.IWIDTH(32)) bus ();
  receive_instr #(.IWIDTH(32), .NUM_INSTR(36), .FIFO_DEPTH(8)) dut (
    .r_clk (clk),
    .r_rst (rst_n),
    .bus   (bus)
  );
  logic start = 1'b0, ready = 1'b0, force_ack = 1'b0;
  logic tx_ack, tx_dly;
  logic [31:0] tx_instr;
  int tx_addr;
  assign bus.r_i_start = start;
  assign bus.r_i_ready = ready;
  assign bus.r_i_ack   = tx_ack | force_ack;
  assign bus.r_i_instr = tx_instr;
  // transmitter: one word per cycle where sync has been high for two consecutive edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dly <= 1'b0; tx_ack <= 1'b0; tx_instr <= '0; tx_addr <= 0;
    end else begin
      tx_dly <= bus.r_o_syn;
      tx_ack <= bus.r_o_syn & tx_dly;
      if (bus.r_o_syn & tx_dly) begin
        tx_instr <= 32'h1000 + 32'(tx_addr);
        tx_addr  <= (tx_addr == 35) ? 0 : tx_addr + 1;
      end
    end
  end
  int checks = 0, errors = 0;
  int acks = 0, done_cnt = 0, occ = 0, max_occ = 0, cyc = 0;
  logic [31:0] got[$];
  int got_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.r_i_ack) acks++;
      if (bus.r_o_done) done_cnt++;
      if (bus.r_o_valid && ready) begin
        got.push_back(bus.r_o_instr);
        got_cyc.push_back(cyc);
      end
      occ = occ + (bus.r_i_ack ? 1 : 0) - ((bus.r_o_valid && ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
    end else occ = 0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 32'(done_cnt != d0), 32'd1);
  endtask
  task automatic chk_words(input string tag, input int base, input int n);
    chk({tag, "_count"}, 32'(got.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < got.size(); i++)
      chk({tag, "_word"}, got[base + i], 32'h1000 + 32'(i));
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_syn"},   32'(bus.r_o_syn),   32'd0);
    chk({tag, "_valid"}, 32'(bus.r_o_valid), 32'd0);
    chk({tag, "_instr"}, bus.r_o_instr,      32'd0);
    chk({tag, "_busy"},  32'(bus.r_o_busy),  32'd0);
    chk({tag, "_done"},  32'(bus.r_o_done),  32'd0);
    chk({tag, "_err"},   32'(bus.r_o_err),   32'd0);
  endtask
  initial begin
    int b, a0, d0, n;
    ready = 1'b1;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    // 1: free-flowing burst with latency checks
    b = got.size(); a0 = acks; d0 = done_cnt;
    pulse_start;
    @(negedge clk);
    chk("t1_syn_after_S", 32'(bus.r_o_syn), 32'd1);
    chk("t1_busy", 32'(bus.r_o_busy), 32'd1);
    chk("t1_valid_S1", 32'(bus.r_o_valid), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("t1_valid_S2", 32'(bus.r_o_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("t1_valid_S3", 32'(bus.r_o_valid), 32'd1);
    chk("t1_first_word", bus.r_o_instr, 32'h1000);
    wait_done("t1_done", 200);
    tick(10);
    chk_words("t1", b, 36);
    chk("t1_acks", 32'(acks - a0), 32'd36);
    chk("t1_done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("t1_no_gaps", 32'((got.size() >= b + 36) ? got_cyc[b + 35] - got_cyc[b] : -1), 32'd35);
    chk("t1_syn_low", 32'(bus.r_o_syn), 32'd0);
    chk("t1_idle", 32'(bus.r_o_busy), 32'd0);
    chk("t1_err", 32'(bus.r_o_err), 32'd0);
    // 2: consumer stalled, FIFO fills to exactly 8
    ready = 1'b0;
    b = got.size(); a0 = acks; d0 = done_cnt;
    pulse_start;
    tick(80);
    chk("t2_acks_full", 32'(acks - a0), 32'd8);
    chk("t2_valid", 32'(bus.r_o_valid), 32'd1);
    chk("t2_head", bus.r_o_instr, 32'h1000);
    chk("t2_syn_low", 32'(bus.r_o_syn), 32'd0);
    chk("t2_busy", 32'(bus.r_o_busy), 32'd1);
    chk("t2_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t2_err", 32'(bus.r_o_err), 32'd0);
    ready = 1'b1;
    wait_done("t2_done", 300);
    tick(10);
    chk_words("t2", b, 36);
    chk("t2_acks", 32'(acks - a0), 32'd36);
    // 3: consumer ready alternates every cycle
    b = got.size(); a0 = acks; d0 = done_cnt;
    max_occ = 0;
    pulse_start;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      ready = ~ready;
      tick(1);
      n++;
    end
    chk("t3_done", 32'(done_cnt != d0), 32'd1);
    ready = 1'b1;
    tick(20);
    chk_words("t3", b, 36);
    chk("t3_max_occ_le_8", 32'(max_occ <= 8), 32'd1);
    chk("t3_acks", 32'(acks - a0), 32'd36);
    chk("t3_err", 32'(bus.r_o_err), 32'd0);
    // 4: extra starts while busy are ignored; restart after done wraps the transmitter
    b = got.size(); a0 = acks; d0 = done_cnt;
    pulse_start;
    tick(5);
    pulse_start;
    tick(10);
    pulse_start;
    wait_done("t4a_done", 200);
    tick(10);
    chk_words("t4a", b, 36);
    chk("t4a_acks", 32'(acks - a0), 32'd36);
    chk("t4a_done_pulse", 32'(done_cnt - d0), 32'd1);
    b = got.size(); a0 = acks;
    pulse_start;
    wait_done("t4b_done", 200);
    tick(10);
    chk_words("t4b", b, 36);
    chk("t4b_acks", 32'(acks - a0), 32'd36);
    // 5: spurious ack in IDLE
    chk("t5_err_before", 32'(bus.r_o_err), 32'd0);
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(bus.r_o_err), 32'd1);
    chk("t5_fifo_empty", 32'(bus.r_o_valid), 32'd0);
    tick(5);
    chk("t5_err_sticky", 32'(bus.r_o_err), 32'd1);
    chk("t5_idle", 32'(bus.r_o_busy), 32'd0);
    // 6: asynchronous reset mid-burst
    b = got.size();
    pulse_start;
    n = 0;
    while (got.size() < b + 10 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t6_ten_words", 32'(got.size() >= b + 10), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_async");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    b = got.size();
    pulse_start;
    wait_done("t6_done", 200);
    tick(10);
    chk_words("t6", b, 36);
    chk("t6_err", 32'(bus.r_o_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
